// File: rtl/adder_pkg.sv
// Shared constants for the adder datapath leaf.
package adder_pkg;

  // Default operand width; instances override it through the WIDTH parameter.
  localparam int unsigned ADDER_DEFAULT_WIDTH = 8;

endpackage : adder_pkg

// File: rtl/adder_full_adder_cell.sv
// One-bit full adder: the single stage of the ripple-carry chain.
// Ports:
//   a, b : operand bits
//   ci   : carry into this stage
//   s    : sum bit
//   co   : carry out of this stage
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  // Propagate term shared by the sum and the carry.
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule : full_adder_cell

// File: rtl/adder.sv
// Parameterised ripple-carry adder with a combinational result and a
// one-cycle registered copy carrying carry, signed-overflow and zero flags.
// Ports:
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset (registered path only)
//   a, b      : operands, unsigned or two's complement
//   cin       : carry-in
//   in_valid  : qualifies a/b/cin for the registered path
//   s, cout   : combinational sum and carry-out, independent of clk/reset
//   s_q       : registered sum
//   cout_q    : registered carry-out
//   ovf_q     : registered signed overflow
//   zero_q    : registered flag, s_q equals zero
//   out_valid : registered path holds a result loaded on the previous edge
module adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic [WIDTH-1:0] s_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             zero_q,
  output logic             out_valid
);

  // c[i] is the carry into bit i; c[WIDTH] is the carry-out.
  logic [WIDTH:0] c;
  logic           ovf;
  logic           zero;

  assign c[0] = cin;

  // Ripple chain of full-adder cells.
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[WIDTH];

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf  = c[WIDTH] ^ c[WIDTH-1];
  assign zero = (s == WIDTH'(0));

  // Result register: loads only on qualified cycles, valid tracks in_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q       <= WIDTH'(0);
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q    <= s;
        cout_q <= cout;
        ovf_q  <= ovf;
        zero_q <= zero;
      end
    end
  end

endmodule : adder

// File: tb/tb_adder.sv
// Randomised and directed bench for adder against an arithmetic reference.
module tb_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         in_valid;
  logic [W-1:0] s;
  logic         cout;
  logic [W-1:0] s_q;
  logic         cout_q;
  logic         ovf_q;
  logic         zero_q;
  logic         out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference registered state
  logic [W-1:0] m_s_q;
  logic         m_cout_q;
  logic         m_ovf_q;
  logic         m_zero_q;
  logic         m_out_valid;

  adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .s         (s),
    .cout      (cout),
    .s_q       (s_q),
    .cout_q    (cout_q),
    .ovf_q     (ovf_q),
    .zero_q    (zero_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Full-precision unsigned sum.
  function automatic int ref_total(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
    return int'(x) + int'(y) + int'(ci);
  endfunction

  // Two's complement value of an operand.
  function automatic int as_signed(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - (1 << W) : int'(x);
  endfunction

  // Signed overflow: true signed result outside the W-bit range.
  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
    int t;
    t = as_signed(x) + as_signed(y) + int'(ci);
    return (t > (1 << (W - 1)) - 1) || (t < -(1 << (W - 1)));
  endfunction

  // Behavioural model of the registered path.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s_q       <= '0;
      m_cout_q    <= 1'b0;
      m_ovf_q     <= 1'b0;
      m_zero_q    <= 1'b1;
      m_out_valid <= 1'b0;
    end else begin
      m_out_valid <= in_valid;
      if (in_valid) begin
        m_s_q    <= W'(ref_total(a, b, cin) % (1 << W));
        m_cout_q <= (ref_total(a, b, cin) >= (1 << W));
        m_ovf_q  <= ref_ovf(a, b, cin);
        m_zero_q <= ((ref_total(a, b, cin) % (1 << W)) == 0);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_comb(input string tag);
    int t;
    t = ref_total(a, b, cin);
    check(tag, 64'({cout, s}), 64'(t));
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".s_q"},       64'(s_q),       64'(m_s_q));
    check({tag, ".cout_q"},    64'(cout_q),    64'(m_cout_q));
    check({tag, ".ovf_q"},     64'(ovf_q),     64'(m_ovf_q));
    check({tag, ".zero_q"},    64'(zero_q),    64'(m_zero_q));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_out_valid));
  endtask

  // Drive a vector on the falling edge, check comb path, then registers after the edge.
  task automatic apply(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic tv);
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = tv;
    #1;
    check_comb({tag, ".comb"});
    @(posedge clk);
    #1;
    check_regs(tag);
  endtask

  initial begin
    reset_n = 1'b1; a = '0; b = '0; cin = 1'b0; in_valid = 1'b0;
    #1 reset_n = 1'b0;

    // Reset held: registers pinned, combinational path live.
    apply("rst_hold0", 8'h0F, 8'h01, 1'b0, 1'b1);
    apply("rst_hold1", 8'hFF, 8'hFF, 1'b1, 1'b1);
    check("rst_zero_q", 64'(zero_q), 64'(1));
    check("rst_s_q", 64'(s_q), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;

    // Directed vectors.
    apply("d_0f_01", 8'h0F, 8'h01, 1'b0, 1'b1);
    check("d_0f_01.s_q_const", 64'(s_q), 64'h10);
    apply("d_wrap",  8'hFF, 8'h01, 1'b0, 1'b1);
    check("d_wrap.zero_const", 64'({cout_q, zero_q, ovf_q}), 64'b110);
    apply("d_ff_ff", 8'hFF, 8'hFF, 1'b1, 1'b1);
    apply("d_7f_01", 8'h7F, 8'h01, 1'b0, 1'b1);
    check("d_7f_01.ovf_const", 64'({s_q, ovf_q}), 64'({8'h80, 1'b1}));
    apply("d_80_80", 8'h80, 8'h80, 1'b0, 1'b1);
    check("d_80_80.flags_const", 64'({cout_q, ovf_q, zero_q}), 64'b111);

    // Back-to-back stream then an idle cycle holding the last result.
    apply("strm0", 8'h12, 8'h34, 1'b0, 1'b1);
    apply("strm1", 8'hA0, 8'h70, 1'b1, 1'b1);
    apply("strm2", 8'h55, 8'h22, 1'b1, 1'b1);
    apply("strm_idle", 8'h00, 8'h00, 1'b0, 1'b0);
    check("strm_idle.hold_const", 64'({s_q, out_valid}), 64'({8'h78, 1'b0}));

    // Asynchronous reset between edges.
    apply("pre_rst", 8'h3C, 8'h0F, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check_regs("async_rst");
    check("async_rst.valid_const", 64'({out_valid, zero_q}), 64'b01);
    @(negedge clk);
    reset_n = 1'b1;

    // Random traffic with random qualification.
    for (int i = 0; i < 300; i++) begin
      apply("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Exhaustive combinational sweep; registered path idles.
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < (1 << (2 * W + 1)); i++) begin
      {cin, a, b} = (2 * W + 1)'(i);
      #1;
      check_comb("sweep");
    end
    @(negedge clk);
    #1;
    check_regs("post_sweep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #5_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_adder
